vend_ctrl_param: RTL
====================

VEND_CTRL_PARAM -- requirements
Module: vend_ctrl_param

Interface
REQ-001 SHALL provide parameter PRICE_UNITS, default 3, item price in 5-Rs units (3 = 15 Rs).
REQ-002 SHALL provide parameter CREDIT_W, default 5, credit register width; constraint PRICE_UNITS+1 <= 2^CREDIT_W-1.
REQ-003 SHALL provide parameter STOCK_W, default 4, stock counter width.
REQ-004 SHALL provide parameter STOCK_INIT, default 10, stock loaded at reset and refill; constraint STOCK_INIT <= 2^STOCK_W-1.
REQ-005 SHALL provide clk  input  1  single clock; all logic updates on its rising edge.
REQ-006 SHALL provide rst  input  1  reset; synchronous, active-high.
REQ-007 SHALL provide in  input  2  coin code: 00 none, 01 = 5 Rs, 10 = 10 Rs, 11 invalid.
REQ-008 SHALL provide cancel  input  1  refund request.
REQ-009 SHALL provide refill  input  1  restock request.
REQ-010 SHALL provide out  output  1  dispense pulse.
REQ-011 SHALL provide change5 / change10  output  1 each  5-Rs / 10-Rs return pulse.
REQ-012 SHALL provide coin_rej  output  1  coin-rejected pulse.
REQ-013 SHALL provide credit  output  CREDIT_W  current credit in 5-Rs units.
REQ-014 SHALL provide sold_out  output  1  high while stock is 0.
REQ-015 SHALL provide busy  output  1  high in VEND or CHANGE.

Function
REQ-016 SHALL use states IDLE, COLLECT, VEND, CHANGE, SOLDOUT; all outputs SHALL be registered.
REQ-017 In IDLE/COLLECT, a valid coin SHALL add 1 (01) or 2 (10) to credit and enter COLLECT.
REQ-018 When post-add credit >= PRICE_UNITS, the FSM SHALL enter VEND; out SHALL be high for exactly the following cycle (latency 1), and credit SHALL drop by PRICE_UNITS and stock by 1 in that cycle.
REQ-019 From VEND, the FSM SHALL go to CHANGE if credit > 0, else SOLDOUT if stock is 0, else IDLE.
REQ-020 In CHANGE, one pulse SHALL be issued per cycle, greedily: credit >= 2 -> change10, credit -= 2; credit == 1 -> change5, credit -= 1.
REQ-021 When credit reaches 0 in CHANGE, the next state SHALL be SOLDOUT if stock is 0, else IDLE.
REQ-022 Code 11, and any non-zero code in VEND/CHANGE/SOLDOUT, SHALL pulse coin_rej for one cycle, latency 1, with credit unchanged.
REQ-023 cancel in COLLECT SHALL enter CHANGE and refund full credit; cancel in any other state SHALL be ignored.
REQ-024 On simultaneous cancel and a valid coin in COLLECT, cancel SHALL win and the coin SHALL be rejected via coin_rej.
REQ-025 refill SHALL be honoured only in IDLE or SOLDOUT: stock <= STOCK_INIT; SOLDOUT -> IDLE.
REQ-026 At most one of change5 and change10 SHALL be high in any cycle.
REQ-027 out SHALL never coincide with a change pulse.

Reset
REQ-028 On rst high at a clock edge: state IDLE, credit 0, stock STOCK_INIT, and out, change5, change10, coin_rej, busy, sold_out all 0.
REQ-029 Reset SHALL override every other input, including mid-VEND and mid-CHANGE; undelivered change SHALL be discarded.

Structure
REQ-030 Package vend_pkg SHALL hold coin-code constants, coin unit values and the state enum typedef.
REQ-031 The greedy change serializer SHALL be one sub-module, vend_change_payout (load credit, emit change5/change10, done).

Verification (defaults unless noted)
REQ-032 Coins 01 then 10 -> out = 1 for one cycle after 10 is sampled; no change; credit 0; stock 9.
REQ-033 Coins 10, 10 -> out pulse, then change5 next cycle, then IDLE with credit 0.
REQ-034 Coin 10 then cancel -> single change10 pulse, no out; coin 01 with cancel in same cycle after a prior 01 -> coin_rej and one change5.
REQ-035 Code 11 in IDLE -> coin_rej for one cycle; credit stays 0; state IDLE.
REQ-036 STOCK_INIT=1: 10, 01 -> out, sold_out = 1; coin 01 -> coin_rej; refill -> sold_out 0, IDLE, and the next purchase is accepted.
REQ-037 PRICE_UNITS=1, coin 10 -> out then change5; rst asserted during CHANGE (PRICE_UNITS=1, prior 10 + cancel) -> all outputs 0 and credit 0 the next cycle.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller: coin codes, coin values in
// 5-Rs units, and the controller state encoding.
package vend_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_BAD  = 2'b11;

  localparam int UNITS_5  = 1;
  localparam int UNITS_10 = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_VEND,
    ST_CHANGE,
    ST_SOLDOUT
  } state_e;

endpackage

// File: rtl/vend_change_payout.sv
// Greedy change serializer: for the credit presented while pay_i is high it
// registers one change10 (credit >= 2) or change5 (credit == 1) pulse and
// reports the credit left after that pulse.
module vend_change_payout
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pay_i,
  input  logic [CREDIT_W-1:0] credit_i,
  output logic [CREDIT_W-1:0] credit_nxt_o,
  output logic                change5_o,
  output logic                change10_o,
  output logic                done_o
);

  logic give10, give5;
  logic change5_q, change10_q;

  always_comb begin
    give10       = (credit_i >= CREDIT_W'(UNITS_10));
    give5        = (credit_i == CREDIT_W'(UNITS_5));
    credit_nxt_o = credit_i;
    if (give10)
      credit_nxt_o = credit_i - CREDIT_W'(UNITS_10);
    else if (give5)
      credit_nxt_o = credit_i - CREDIT_W'(UNITS_5);
    done_o = (credit_i == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      change5_q  <= 1'b0;
      change10_q <= 1'b0;
    end else begin
      change5_q  <= pay_i & give5;
      change10_q <= pay_i & give10;
    end
  end

  assign change5_o  = change5_q;
  assign change10_o = change10_q;

endmodule

// File: rtl/vend_ctrl_param.sv
// Parameterised vending controller: collects 5/10-Rs coins, dispenses at
// PRICE_UNITS, pays change greedily, tracks stock and supports refill/cancel.
module vend_ctrl_param
  import vend_pkg::*;
#(
  parameter int PRICE_UNITS = 3,
  parameter int CREDIT_W    = 5,
  parameter int STOCK_W     = 4,
  parameter int STOCK_INIT  = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          in,
  input  logic                cancel,
  input  logic                refill,
  output logic                out,
  output logic                change5,
  output logic                change10,
  output logic                coin_rej,
  output logic [CREDIT_W-1:0] credit,
  output logic                sold_out,
  output logic                busy
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE_UNITS);
  localparam logic [STOCK_W-1:0]  STOCK_C = STOCK_W'(STOCK_INIT);

  state_e               state_q, state_d;
  logic [CREDIT_W-1:0]  credit_q, credit_d, coin_units, sum, credit_nxt;
  logic [STOCK_W-1:0]   stock_q, stock_d;
  logic                 out_q, out_d, rej_q, rej_d, busy_q, sold_q;
  logic                 coin_ok, pay, pay_done;

  vend_change_payout #(.CREDIT_W(CREDIT_W)) u_payout (
    .clk          (clk),
    .rst          (rst),
    .pay_i        (pay),
    .credit_i     (credit_q),
    .credit_nxt_o (credit_nxt),
    .change5_o    (change5),
    .change10_o   (change10),
    .done_o       (pay_done)
  );

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    stock_d    = stock_q;
    out_d      = 1'b0;
    rej_d      = 1'b0;
    pay        = 1'b0;
    coin_ok    = (in == COIN_5) || (in == COIN_10);
    coin_units = '0;
    if (in == COIN_5)
      coin_units = CREDIT_W'(UNITS_5);
    else if (in == COIN_10)
      coin_units = CREDIT_W'(UNITS_10);
    sum = credit_q + coin_units;

    unique case (state_q)
      ST_IDLE, ST_COLLECT: begin
        // Cancel beats a coin arriving in the same cycle; that coin bounces.
        if (state_q == ST_COLLECT && cancel) begin
          pay      = 1'b1;
          credit_d = credit_nxt;
          state_d  = ST_CHANGE;
          rej_d    = (in != COIN_NONE);
        end else if (coin_ok) begin
          if (sum >= PRICE_C) begin
            state_d  = ST_VEND;
            credit_d = sum - PRICE_C;
            stock_d  = stock_q - STOCK_W'(1);
            out_d    = 1'b1;
          end else begin
            state_d  = ST_COLLECT;
            credit_d = sum;
          end
        end else begin
          rej_d = (in == COIN_BAD);
          if (state_q == ST_IDLE && refill)
            stock_d = STOCK_C;
        end
      end
      ST_VEND, ST_CHANGE: begin
        rej_d = (in != COIN_NONE);
        if (!pay_done) begin
          pay      = 1'b1;
          credit_d = credit_nxt;
          state_d  = ST_CHANGE;
        end else begin
          state_d = (stock_q == '0) ? ST_SOLDOUT : ST_IDLE;
        end
      end
      ST_SOLDOUT: begin
        rej_d = (in != COIN_NONE);
        if (refill) begin
          stock_d = STOCK_C;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
      stock_q  <= STOCK_C;
      out_q    <= 1'b0;
      rej_q    <= 1'b0;
      busy_q   <= 1'b0;
      sold_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      stock_q  <= stock_d;
      out_q    <= out_d;
      rej_q    <= rej_d;
      busy_q   <= (state_d == ST_VEND) || (state_d == ST_CHANGE);
      sold_q   <= (stock_d == '0);
    end
  end

  assign out      = out_q;
  assign coin_rej = rej_q;
  assign credit   = credit_q;
  assign sold_out = sold_q;
  assign busy     = busy_q;

endmodule
